// File: rtl/xrv1_pkg.sv
// rtl/xrv1_pkg.sv - shared constants for the xrv1 core slice
package xrv1_pkg;

    localparam int XRV_WB_BUF_DEPTH = 4;

endpackage

// File: rtl/xrv1_wb_buf_mem.sv
// rtl/xrv1_wb_buf_mem.sv - DEPTH_P x WIDTH_P register array, one write port, one async read port
module xrv1_wb_buf_mem #(
    parameter int WIDTH_P = 40,
    parameter int DEPTH_P = 4,
    localparam int ADDR_W = $clog2(DEPTH_P)
) (
    input  logic               clk_i,
    input  logic               wr_en_i,
    input  logic [ADDR_W-1:0]  wr_addr_i,
    input  logic [WIDTH_P-1:0] wr_data_i,
    input  logic [ADDR_W-1:0]  rd_addr_i,
    output logic [WIDTH_P-1:0] rd_data_o
);

    logic [WIDTH_P-1:0] mem [DEPTH_P];

    // Contents are deliberately left unreset; occupancy is tracked by the owner.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem[rd_addr_i];

endmodule

// File: rtl/xrv1_alu_wb_buf.sv
// rtl/xrv1_alu_wb_buf.sv - in-order result buffer between the ALU and the writeback arbiter
module xrv1_alu_wb_buf
    import xrv1_pkg::*;
#(
    parameter int DATA_WIDTH_P = 32,
    parameter     ITAG_WIDTH_P = "inv",
    parameter int DEPTH_P      = XRV_WB_BUF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH_P),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    alu_done_i,
    input  logic [DATA_WIDTH_P-1:0] alu_res_i,
    input  logic [ITAG_WIDTH_P-1:0] alu_itag_i,
    output logic                    alu_rdy_o,
    output logic                    wb_vld_o,
    input  logic                    wb_rdy_i,
    output logic [DATA_WIDTH_P-1:0] wb_data_o,
    output logic [ITAG_WIDTH_P-1:0] wb_itag_o,
    output logic [CNT_W-1:0]        count_o,
    output logic                    overflow_o
);

    localparam int ENTRY_W = ITAG_WIDTH_P + DATA_WIDTH_P;

    if (ITAG_WIDTH_P == 32'("inv")) begin : g_itag_chk
        $error("xrv1_alu_wb_buf: ITAG_WIDTH_P must be overridden");
    end
    if ((DEPTH_P < 2) || ((DEPTH_P & (DEPTH_P - 1)) != 0)) begin : g_depth_chk
        $error("xrv1_alu_wb_buf: DEPTH_P must be a power of 2 and at least 2");
    end

    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               overflow_q;
    logic               full;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] rd_entry;

    // Ready and valid come from registered occupancy only, so the same-cycle
    // ALU request/complete loop never sees wb_rdy_i or alu_done_i.
    assign full      = (count_q == CNT_W'(DEPTH_P));
    assign alu_rdy_o = !full;
    assign wb_vld_o  = (count_q != '0);
    assign push      = alu_done_i && alu_rdy_o;
    assign pop       = wb_vld_o && wb_rdy_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (alu_done_i && full) begin
                overflow_q <= 1'b1;
            end
            if (flush_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    xrv1_wb_buf_mem #(
        .WIDTH_P (ENTRY_W),
        .DEPTH_P (DEPTH_P)
    ) u_mem (
        .clk_i     (clk_i),
        .wr_en_i   (push && !flush_i),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i ({alu_itag_i, alu_res_i}),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_entry)
    );

    assign {wb_itag_o, wb_data_o} = rd_entry;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

    overflow_push_dropped : assert property (@(posedge clk_i) disable iff (rst_i)
        !(alu_done_i && full))
        else $warning("xrv1_alu_wb_buf: ALU result dropped, buffer full");

endmodule

// File: tb/tb_xrv1_alu_wb_buf.sv
// tb/tb_xrv1_alu_wb_buf.sv - vector, sequence and random-model bench for xrv1_alu_wb_buf
module tb_xrv1_alu_wb_buf;
    import xrv1_pkg::*;

    localparam int DW = 32;
    localparam int IW = 8;
    localparam int D  = XRV_WB_BUF_DEPTH;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          done;
    logic [DW-1:0] res;
    logic [IW-1:0] itag;
    logic          alu_rdy;
    logic          wb_vld;
    logic          wb_rdy;
    logic [DW-1:0] wb_data;
    logic [IW-1:0] wb_itag;
    logic [CW-1:0] count;
    logic          ovf;

    xrv1_alu_wb_buf #(
        .DATA_WIDTH_P (DW),
        .ITAG_WIDTH_P (IW),
        .DEPTH_P      (D)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .alu_done_i (done),
        .alu_res_i  (res),
        .alu_itag_i (itag),
        .alu_rdy_o  (alu_rdy),
        .wb_vld_o   (wb_vld),
        .wb_rdy_i   (wb_rdy),
        .wb_data_o  (wb_data),
        .wb_itag_o  (wb_itag),
        .count_o    (count),
        .overflow_o (ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] data_of(input logic [IW-1:0] t);
        return 32'hA500_0000 | DW'(t);
    endfunction

    task automatic drive(input logic f, input logic d, input logic [IW-1:0] t, input logic r);
        flush = f;
        done  = d;
        itag  = t;
        res   = data_of(t);
        wb_rdy = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string name, input logic e_vld, input int e_cnt,
                             input logic [IW-1:0] e_tag, input logic e_ovf);
        chk({name, ".vld"}, 64'(wb_vld), 64'(e_vld));
        chk({name, ".count"}, 64'(count), 64'(e_cnt));
        chk({name, ".alu_rdy"}, 64'(alu_rdy), 64'(e_cnt < D));
        chk({name, ".ovf"}, 64'(ovf), 64'(e_ovf));
        if (e_vld) begin
            chk({name, ".itag"}, 64'(wb_itag), 64'(e_tag));
            chk({name, ".data"}, 64'(wb_data), 64'(data_of(e_tag)));
        end
    endtask

    typedef struct {
        logic          fl;
        logic          dn;
        logic [IW-1:0] tg;
        logic          rdy;
        logic          e_vld;
        int            e_cnt;
        logic [IW-1:0] e_tag;
        logic          e_ovf;
    } vec_t;

    typedef struct packed {
        logic [IW-1:0] t;
        logic [DW-1:0] d;
    } ent_t;

    vec_t vecs[18];
    ent_t model_q[$];
    logic model_ovf;

    initial begin
        // {flush, done, itag, wb_rdy, exp_vld, exp_count, exp_head_itag, exp_ovf}
        vecs[0]  = '{0, 1, 3, 1, 1, 1, 3, 0};
        vecs[1]  = '{0, 0, 0, 1, 0, 0, 0, 0};
        vecs[2]  = '{0, 1, 0, 0, 1, 1, 0, 0};
        vecs[3]  = '{0, 1, 1, 0, 1, 2, 0, 0};
        vecs[4]  = '{0, 1, 2, 0, 1, 3, 0, 0};
        vecs[5]  = '{0, 1, 3, 0, 1, 4, 0, 0};
        vecs[6]  = '{0, 1, 7, 0, 1, 4, 0, 1};
        vecs[7]  = '{0, 0, 0, 1, 1, 3, 1, 1};
        vecs[8]  = '{0, 0, 0, 1, 1, 2, 2, 1};
        vecs[9]  = '{0, 0, 0, 1, 1, 1, 3, 1};
        vecs[10] = '{0, 0, 0, 1, 0, 0, 0, 1};
        vecs[11] = '{0, 1, 5, 0, 1, 1, 5, 1};
        vecs[12] = '{0, 1, 6, 0, 1, 2, 5, 1};
        vecs[13] = '{1, 1, 9, 1, 0, 0, 0, 1};
        vecs[14] = '{0, 0, 0, 1, 0, 0, 0, 1};
        vecs[15] = '{0, 1, 4, 0, 1, 1, 4, 1};
        vecs[16] = '{0, 0, 0, 1, 0, 0, 0, 1};
        vecs[17] = '{0, 0, 0, 0, 0, 0, 0, 1};

        rst = 1'b1;
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 0, 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].fl, vecs[i].dn, vecs[i].tg, vecs[i].rdy);
            tick();
            chk_state($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_cnt, vecs[i].e_tag, vecs[i].e_ovf);
        end

        // Head holds steady under backpressure with a full buffer.
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, IW'(i), 0);
            tick();
        end
        drive(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_state($sformatf("hold%0d", i), 1, 4, 0, 1);
        end

        // Async reset between edges with count=3 and overflow set.
        drive(1, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, IW'(i + 1), 0);
            tick();
        end
        drive(0, 0, 0, 0);
        chk_state("pre_rst", 1, 3, 1, 1);
        #2 rst = 1'b1;
        #1 chk_state("async_rst", 0, 0, 0, 0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        drive(0, 1, 2, 0);
        tick();
        chk_state("post_rst_push", 1, 1, 2, 0);
        drive(0, 0, 0, 1);
        tick();
        chk_state("post_rst_drain", 0, 0, 0, 0);

        // Concurrent push and pop every cycle across three pointer wraps.
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, IW'(i), 1);
            tick();
            chk_state($sformatf("wrap%0d", i), 1, 1, IW'(i), 0);
        end
        drive(0, 0, 0, 1);
        tick();
        chk_state("wrap_end", 0, 0, 0, 0);

        // Random traffic against a queue model.
        model_q.delete();
        model_ovf = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic f, d, r;
            ent_t e;
            int pre;
            f = ($urandom_range(0, 19) == 0);
            d = $urandom_range(0, 1) == 1;
            r = $urandom_range(0, 2) != 0;
            e.t = IW'($urandom);
            e.d = $urandom;
            flush = f; done = d; itag = e.t; res = e.d; wb_rdy = r;
            pre = model_q.size();
            if (d && pre == D) model_ovf = 1'b1;
            if (f) begin
                model_q.delete();
            end else begin
                if (r && pre > 0) void'(model_q.pop_front());
                if (d && pre < D) model_q.push_back(e);
            end
            tick();
            chk("rnd.count", 64'(count), 64'(model_q.size()));
            chk("rnd.vld", 64'(wb_vld), 64'(model_q.size() != 0));
            chk("rnd.alu_rdy", 64'(alu_rdy), 64'(model_q.size() < D));
            chk("rnd.ovf", 64'(ovf), 64'(model_ovf));
            if (model_q.size() != 0) begin
                chk("rnd.itag", 64'(wb_itag), 64'(model_q[0].t));
                chk("rnd.data", 64'(wb_data), 64'(model_q[0].d));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
